// File: rtl/edge_pack_writer.sv
// Packs raster-ordered 1-bit Sobel edge decisions into 16-bit words and writes them to the
// edge frame buffer. It also tracks frame completion, the per-frame edge count and sequence errors.
//
//   state    | meaning
//   S_IDLE   | waiting for pixel (0,0); accepted pixels are discarded
//   S_ACTIVE | packing a frame, expecting the next raster coordinate
module edge_pack_writer #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  logic              i_edge,
    input  logic              i_err_clr,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [15:0]       o_wdata,
    output logic              o_frame_done,
    output logic [16:0]       o_edge_count,
    output logic              o_busy,
    output logic              o_err_seq
);

    localparam logic [9:0] X_LIM  = 10'(H_RES);
    localparam logic [9:0] Y_LIM  = 10'(V_RES);
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);
    localparam int         WPL    = H_RES / 16;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t              r_state;
    logic [9:0]          r_exp_x;
    logic [9:0]          r_exp_y;
    logic [15:0]         r_shift;
    logic [16:0]         r_count;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [15:0]         r_wdata;
    logic                r_frame_done;
    logic [16:0]         r_edge_count;
    logic                r_err_seq;

    state_t              w_state_n;
    logic [9:0]          w_exp_x_n;
    logic [9:0]          w_exp_y_n;
    logic [15:0]         w_shift_n;
    logic [16:0]         w_count_n;
    logic [15:0]         w_word;
    logic [16:0]         w_count_sum;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_acc;
    logic                w_origin;
    logic                w_match;
    logic                w_pack;
    logic                w_restart;
    logic                w_err_set;
    logic                w_emit;
    logic                w_last;

    assign w_acc    = i_valid && (i_x < X_LIM) && (i_y < Y_LIM);
    assign w_origin = (i_x == 10'd0) && (i_y == 10'd0);
    assign w_match  = (i_x == r_exp_x) && (i_y == r_exp_y);
    assign w_addr   = ADDR_W'(i_y) * ADDR_W'(WPL) + ADDR_W'(i_x[9:4]);

    always_comb begin
        w_state_n   = r_state;
        w_exp_x_n   = r_exp_x;
        w_exp_y_n   = r_exp_y;
        w_shift_n   = r_shift;
        w_count_n   = r_count;
        w_pack      = 1'b0;
        w_restart   = 1'b0;
        w_err_set   = 1'b0;

        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (w_origin) begin
                        w_pack    = 1'b1;
                        w_restart = 1'b1;
                        w_state_n = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_match) begin
                        w_pack = 1'b1;
                    end else if (w_origin) begin
                        w_pack    = 1'b1;
                        w_restart = 1'b1;
                        w_err_set = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end

        // A fresh word starts at bit 0, so stale bits never leak across words or frames
        w_word              = (i_x[3:0] == 4'd0) ? 16'h0000 : r_shift;
        w_word[i_x[3:0]]    = i_edge;
        w_count_sum         = (w_restart ? 17'd0 : r_count) + {16'd0, i_edge};
        w_last              = w_pack && (i_x == X_LAST) && (i_y == Y_LAST);
        w_emit              = w_pack && (i_x[3:0] == 4'hF);

        if (w_pack) begin
            w_shift_n = w_word;
            w_count_n = w_count_sum;
            if (i_x == X_LAST) begin
                w_exp_x_n = 10'd0;
                w_exp_y_n = i_y + 10'd1;
            end else begin
                w_exp_x_n = i_x + 10'd1;
                w_exp_y_n = i_y;
            end
            if (w_last)
                w_state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_exp_x      <= '0;
            r_exp_y      <= '0;
            r_shift      <= '0;
            r_count      <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
            r_edge_count <= '0;
            r_err_seq    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_exp_x      <= w_exp_x_n;
            r_exp_y      <= w_exp_y_n;
            r_shift      <= w_shift_n;
            r_count      <= w_count_n;
            r_we         <= w_emit;
            r_frame_done <= w_last;
            if (w_emit) begin
                r_waddr <= w_addr;
                r_wdata <= w_word;
            end
            if (w_last)
                r_edge_count <= w_count_sum;
            // set has priority over clear
            r_err_seq    <= w_err_set | (r_err_seq & ~i_err_clr);
        end
    end

    assign o_we         = r_we;
    assign o_waddr      = r_waddr;
    assign o_wdata      = r_wdata;
    assign o_frame_done = r_frame_done;
    assign o_edge_count = r_edge_count;
    assign o_busy       = (r_state == S_ACTIVE);
    assign o_err_seq    = r_err_seq;

endmodule

// File: tb/tb_edge_pack_writer.sv
// Directed bench for edge_pack_writer on a reduced 48x4 frame (12 words, 3 words per line).
module tb_edge_pack_writer;

    localparam int H  = 48;
    localparam int V  = 4;
    localparam int AW = 4;
    localparam int NW = H * V / 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid, i_edge, i_err_clr;
    logic [9:0]    i_x, i_y;
    logic          o_we, o_frame_done, o_busy, o_err_seq;
    logic [AW-1:0] o_waddr;
    logic [15:0]   o_wdata;
    logic [16:0]   o_edge_count;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt, fd_cnt, lat_err;
    logic [15:0] mem [16];
    logic clr = 1'b0;

    edge_pack_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_x(i_x), .i_y(i_y),
        .i_edge(i_edge), .i_err_clr(i_err_clr), .o_we(o_we), .o_waddr(o_waddr),
        .o_wdata(o_wdata), .o_frame_done(o_frame_done), .o_edge_count(o_edge_count),
        .o_busy(o_busy), .o_err_seq(o_err_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0; fd_cnt = 0; lat_err = 0;
        for (int a = 0; a < 16; a++) mem[a] = 16'hDEAD;
    endtask

    // Drive one cycle from a negedge, then log outputs at the next negedge.
    task automatic cyc(input int x, input int y, input bit e, input bit v, input bit ew);
        logic [31:0] xv, yv;
        xv = x; yv = y;
        i_valid = v; i_x = xv[9:0]; i_y = yv[9:0]; i_edge = e; i_err_clr = clr;
        @(negedge clk);
        if (o_we !== ew) lat_err++;
        if (o_frame_done && !o_we) lat_err++;
        if (o_we) begin wr_cnt++; mem[o_waddr] = o_wdata; end
        if (o_frame_done) fd_cnt++;
    endtask

    // mode 0: edge only at x=5, mode 1: all ones; gap 0 none, 1 invalid cycle per pixel, 2 blanking at line end
    task automatic run(input int x0, input int y0, input int x1, input int y1,
                       input int mode, input int gap, input bit wen);
        int x, y;
        bit done;
        x = x0; y = y0; done = 0;
        while (!done) begin
            cyc(x, y, (mode == 1) ? 1'b1 : (x == 5), 1'b1, wen && (x % 16 == 15));
            if (gap == 1) cyc(0, 0, 1'b1, 1'b0, 1'b0);
            if (gap == 2 && x == H - 1) cyc(H + 2, y, 1'b1, 1'b1, 1'b0);
            if (x == x1 && y == y1) done = 1;
            else if (x == H - 1) begin x = 0; y++; end
            else x++;
        end
    endtask

    task automatic chk_mem(input string tag, input int mode);
        for (int a = 0; a < NW; a++)
            chk(tag, {16'd0, mem[a]},
                (mode == 1) ? 32'hFFFF : ((a % 3 == 0) ? 32'h0020 : 32'h0000));
    endtask

    initial begin
        reset = 1'b1; i_valid = 0; i_x = 0; i_y = 0; i_edge = 0; i_err_clr = 0;
        clear_log();
        @(negedge clk); @(negedge clk);
        chk("rst_we", {31'd0, o_we}, 0);
        chk("rst_waddr", {28'd0, o_waddr}, 0);
        chk("rst_wdata", {16'd0, o_wdata}, 0);
        chk("rst_fd", {31'd0, o_frame_done}, 0);
        chk("rst_cnt", {15'd0, o_edge_count}, 0);
        chk("rst_busy", {31'd0, o_busy}, 0);
        chk("rst_err", {31'd0, o_err_seq}, 0);
        reset = 1'b0;

        // single-column edge frame with blanking after every line
        clear_log();
        run(0, 0, H - 1, V - 1, 0, 2, 1);
        chk("f1_writes", wr_cnt, NW);
        chk("f1_latency", lat_err, 0);
        chk("f1_done", fd_cnt, 1);
        chk("f1_count", {15'd0, o_edge_count}, V);
        chk("f1_busy", {31'd0, o_busy}, 0);
        chk("f1_err", {31'd0, o_err_seq}, 0);
        chk_mem("f1_data", 0);

        // all-ones frame, valid toggling
        clear_log();
        run(0, 0, H - 1, V - 1, 1, 1, 1);
        chk("f2_writes", wr_cnt, NW);
        chk("f2_latency", lat_err, 0);
        chk("f2_done", fd_cnt, 1);
        chk("f2_count", {15'd0, o_edge_count}, H * V);
        chk_mem("f2_data", 1);

        // mid-frame start is ignored until (0,0)
        clear_log();
        run(37, 2, H - 1, V - 1, 1, 0, 0);
        chk("f3_idle_writes", wr_cnt, 0);
        chk("f3_idle_busy", {31'd0, o_busy}, 0);
        run(0, 0, H - 1, V - 1, 0, 0, 1);
        chk("f3_writes", wr_cnt, NW);
        chk("f3_latency", lat_err, 0);
        chk("f3_count", {15'd0, o_edge_count}, V);
        chk("f3_err", {31'd0, o_err_seq}, 0);

        // skipped pixel (20,2): words 0..6 written, nothing from word 7 on
        clear_log();
        run(0, 0, 19, 2, 1, 0, 1);
        run(21, 2, H - 1, V - 1, 1, 0, 0);
        chk("skip_writes", wr_cnt, 7);
        chk("skip_latency", lat_err, 0);
        chk("skip_done", fd_cnt, 0);
        chk("skip_err", {31'd0, o_err_seq}, 1);
        chk("skip_busy", {31'd0, o_busy}, 0);
        chk("skip_cnt_hold", {15'd0, o_edge_count}, V);
        chk("skip_word7", {16'd0, mem[7]}, 32'hDEAD);
        clear_log();
        run(0, 0, H - 1, V - 1, 0, 0, 1);
        chk("resume_writes", wr_cnt, NW);
        chk("resume_err_sticky", {31'd0, o_err_seq}, 1);
        clr = 1'b1;
        cyc(0, 0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        chk("err_clr", {31'd0, o_err_seq}, 0);

        // (0,0) injected at (30,2) with a simultaneous clear: set wins, frame restarts
        clear_log();
        run(0, 0, 29, 2, 1, 0, 1);
        clr = 1'b1;
        cyc(0, 0, 1'b0, 1'b1, 1'b0);
        clr = 1'b0;
        chk("restart_err", {31'd0, o_err_seq}, 1);
        chk("restart_busy", {31'd0, o_busy}, 1);
        run(1, 0, H - 1, V - 1, 0, 0, 1);
        chk("restart_writes", wr_cnt, 7 + NW);
        chk("restart_latency", lat_err, 0);
        chk("restart_done", fd_cnt, 1);
        chk("restart_count", {15'd0, o_edge_count}, V);
        chk_mem("restart_data", 0);
        clr = 1'b1;
        cyc(0, 0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;

        // reset asserted during the write of word 5
        clear_log();
        run(0, 0, H - 1, 1, 0, 0, 1);
        chk("pre_rst_we", {31'd0, o_we}, 1);
        chk("pre_rst_addr", {28'd0, o_waddr}, 5);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", {31'd0, o_we}, 0);
        chk("mid_rst_addr", {28'd0, o_waddr}, 0);
        chk("mid_rst_data", {16'd0, o_wdata}, 0);
        chk("mid_rst_fd", {31'd0, o_frame_done}, 0);
        chk("mid_rst_cnt", {15'd0, o_edge_count}, 0);
        chk("mid_rst_busy", {31'd0, o_busy}, 0);
        chk("mid_rst_err", {31'd0, o_err_seq}, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        run(0, 0, H - 1, V - 1, 0, 0, 1);
        chk("post_rst_writes", wr_cnt, NW);
        chk("post_rst_latency", lat_err, 0);
        chk("post_rst_done", fd_cnt, 1);
        chk("post_rst_count", {15'd0, o_edge_count}, V);
        chk_mem("post_rst_data", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
